// File: rtl/mux_pair_arbiter.sv
// Round-robin arbiter and capture stage around genericMux2x1: drives sel, registers f, offers it via valid/ready.
// Define ARB_FIXED_PRIORITY_EN to make req1 always win contention instead of alternating.
module mux_pair_arbiter #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         req1,
    input  logic [n-1:0] f,
    input  logic         dataReady,
    output logic         sel,
    output logic         ack0,
    output logic         ack1,
    output logic [n-1:0] dataOut,
    output logic         dataValid
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_OUT = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         sel_q, sel_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic [n-1:0] data_out_q, data_out_d;
    logic         data_valid_q, data_valid_d;
    logic         any_req;
    logic         grant_ch;

    assign any_req = req0 | req1;

`ifdef ARB_FIXED_PRIORITY_EN
    assign grant_ch = req1;
`else
    logic last_grant_q, last_grant_d;

    // Resetting to 1 lets channel 0 win the very first contention.
    assign grant_ch = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && any_req)
            last_grant_d = grant_ch;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant_q <= 1'b1;
        else
            last_grant_q <= last_grant_d;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (any_req) state_d = CAPTURE;
            CAPTURE:  state_d = WAIT_OUT;
            WAIT_OUT: if (data_valid_q && dataReady) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // CAPTURE samples f one cycle after the grant, once the mux has settled on the registered sel.
    always_comb begin
        sel_d        = sel_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        case (state_q)
            IDLE: begin
                if (any_req)
                    sel_d = grant_ch;
            end
            CAPTURE: begin
                data_out_d   = f;
                data_valid_d = 1'b1;
                ack0_d       = ~sel_q;
                ack1_d       = sel_q;
            end
            WAIT_OUT: begin
                if (data_valid_q && dataReady)
                    data_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign sel       = sel_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign dataOut   = data_out_q;
    assign dataValid = data_valid_q;

endmodule

// File: tb/tb_mux_pair_arbiter.sv
// Self-checking bench for mux_pair_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mux_pair_arbiter;

`ifdef ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, req0, req1, dataReady;
    logic [7:0] y0, y1, f;
    logic       sel, ack0, ack1, dataValid;
    logic [7:0] dataOut;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         rst, r0, r1, rdy;
        logic [7:0] a, b;
        bit         es, ea0, ea1;
        logic [7:0] ed;
        bit         ev;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: one transfer record plus the round-robin memory.
    bit         m_busy, m_captured, m_last, m_sel, m_ack0, m_ack1, m_valid;
    logic [7:0] m_dout;

    mux_pair_arbiter #(.n(8)) dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .f(f),
        .dataReady(dataReady), .sel(sel), .ack0(ack0), .ack1(ack1),
        .dataOut(dataOut), .dataValid(dataValid)
    );

    // Stand-in for genericMux2x1.
    assign f = sel ? y1 : y0;

    always #5 clk = ~clk;

    function automatic vec_t mk(bit rst, bit r0, bit r1, bit rdy, logic [7:0] a, logic [7:0] b,
                                bit es, bit ea0, bit ea1, logic [7:0] ed, bit ev);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.rdy = rdy; v.a = a; v.b = b;
        v.es = es; v.ea0 = ea0; v.ea1 = ea1; v.ed = ed; v.ev = ev;
        return v;
    endfunction

    task automatic checkOne(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(string tag, bit es, bit ea0, bit ea1, logic [7:0] ed, bit ev);
        checkOne({tag, ".sel"},       {7'b0, sel},       {7'b0, es});
        checkOne({tag, ".ack0"},      {7'b0, ack0},      {7'b0, ea0});
        checkOne({tag, ".ack1"},      {7'b0, ack1},      {7'b0, ea1});
        checkOne({tag, ".dataOut"},   dataOut,           ed);
        checkOne({tag, ".dataValid"}, {7'b0, dataValid}, {7'b0, ev});
    endtask

    task automatic applyStimulus(bit r, bit r0, bit r1, bit rdy, logic [7:0] a, logic [7:0] b);
        @(negedge clk);
        reset = r; req0 = r0; req1 = r1; dataReady = rdy; y0 = a; y1 = b;
        @(posedge clk);
        #1;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        bit ch;
        m_ack0 = 1'b0;
        m_ack1 = 1'b0;
        if (!m_busy) begin
            if (req0 || req1) begin
                if (req0 && req1) ch = FIXED ? 1'b1 : !m_last;
                else              ch = req1;
                m_sel = ch; m_last = ch; m_busy = 1'b1; m_captured = 1'b0;
            end
        end else if (!m_captured) begin
            m_dout = m_sel ? y1 : y0;
            m_valid = 1'b1;
            if (m_sel) m_ack1 = 1'b1; else m_ack0 = 1'b1;
            m_captured = 1'b1;
        end else if (dataReady) begin
            m_valid = 1'b0;
            m_busy  = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] prev;
        bit ch;
        bit exp_first;

        reset = 1'b1; req0 = 1'b0; req1 = 1'b0; dataReady = 1'b0; y0 = 8'h00; y1 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

        // Single channel-0 transfer, then a fresh reset and four contended transfers.
        vecs.push_back(mk(0, 1, 0, 1, 8'hA5, 8'h5A, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 8'hA5, 8'h5A, 0, 1, 0, 8'hA5, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(0, 0, 0, 1, 8'hA5, 8'h5A, 0, 0, 0, 8'hA5, 0));
        vecs.push_back(mk(1, 0, 0, 1, 8'h11, 8'h22, 0, 0, 0, 8'h00, 0));
        prev = 8'h00;
        for (int g = 0; g < 4; g++) begin
            ch = FIXED ? 1'b1 : g[0];
            vecs.push_back(mk(0, 1, 1, 1, 8'h11, 8'h22, ch, 0, 0, prev, 0));
            prev = ch ? 8'h22 : 8'h11;
            vecs.push_back(mk(0, 1, 1, 1, 8'h11, 8'h22, ch, !ch, ch, prev, 1));
            vecs.push_back(mk(0, 1, 1, 1, 8'h11, 8'h22, ch, 0, 0, prev, 0));
        end
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].rdy, vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i].es, vecs[i].ea0, vecs[i].ea1, vecs[i].ed, vecs[i].ev);
        end

        // Backpressure: output held for 5 cycles, req1 must not be granted until release.
        applyStimulus(1, 0, 0, 0, 8'h5C, 8'hA7);
        applyStimulus(0, 1, 0, 0, 8'h5C, 8'hA7);
        checkOutput("bp.grant", 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h5C, 8'hA7);
        checkOutput("bp.capture", 0, 1, 0, 8'h5C, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 1, 0, 8'h5C, 8'hA7);
            checkOutput($sformatf("bp.hold%0d", i), 0, 0, 0, 8'h5C, 1);
        end
        applyStimulus(0, 0, 1, 1, 8'h5C, 8'hA7);
        checkOutput("bp.release", 0, 0, 0, 8'h5C, 0);
        applyStimulus(0, 0, 1, 1, 8'h5C, 8'hA7);
        checkOutput("bp.grant1", 1, 0, 0, 8'h5C, 0);
        applyStimulus(0, 0, 1, 1, 8'h5C, 8'hA7);
        checkOutput("bp.capture1", 1, 0, 1, 8'hA7, 1);

        // Reset during CAPTURE: asynchronous clear, no ack, round-robin memory restored.
        applyStimulus(1, 0, 0, 1, 8'h33, 8'h44);
        applyStimulus(0, 0, 1, 1, 8'h33, 8'h44);
        checkOutput("rc.grant", 1, 0, 0, 8'h00, 0);
        reset = 1'b1;
        #1;
        checkOutput("rc.async", 0, 0, 0, 8'h00, 0);
        applyStimulus(1, 0, 1, 1, 8'h33, 8'h44);
        checkOutput("rc.held", 0, 0, 0, 8'h00, 0);
        exp_first = FIXED;
        applyStimulus(0, 1, 1, 1, 8'h33, 8'h44);
        checkOutput("rc.first", exp_first, 0, 0, 8'h00, 0);

        // A one-cycle req1 pulse during WAIT_OUT is never seen.
        applyStimulus(1, 0, 0, 0, 8'h3C, 8'hC3);
        applyStimulus(0, 1, 0, 0, 8'h3C, 8'hC3);
        checkOutput("pw.grant", 0, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h3C, 8'hC3);
        checkOutput("pw.capture", 0, 1, 0, 8'h3C, 1);
        applyStimulus(0, 0, 1, 0, 8'h3C, 8'hC3);
        checkOutput("pw.pulse", 0, 0, 0, 8'h3C, 1);
        applyStimulus(0, 0, 0, 1, 8'h3C, 8'hC3);
        checkOutput("pw.release", 0, 0, 0, 8'h3C, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 8'h3C, 8'hC3);
            checkOutput($sformatf("pw.idle%0d", i), 0, 0, 0, 8'h3C, 0);
        end

        // Randomized traffic against the model.
        applyStimulus(1, 0, 0, 0, 8'h00, 8'h00);
        m_busy = 0; m_captured = 0; m_last = 1; m_sel = 0;
        m_ack0 = 0; m_ack1 = 0; m_valid = 0; m_dout = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!req0)      req0 = ($urandom_range(0, 2) == 0);
            else if (m_ack0) req0 = 1'($urandom_range(0, 1));
            if (!req1)      req1 = ($urandom_range(0, 2) == 0);
            else if (m_ack1) req1 = 1'($urandom_range(0, 1));
            dataReady = ($urandom_range(0, 9) < 7);
            y0 = 8'($urandom);
            y1 = 8'($urandom);
            @(posedge clk);
            modelStep();
            #1;
            checkOutput($sformatf("rand%0d", c), m_sel, m_ack0, m_ack1, m_dout, m_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
